// File: rtl/decimator.sv
// Keep-one-in-N decimator with an output FIFO and valid/ready on both sides.
// Define DECIMATOR_LEVEL_EN to expose the registered FIFO occupancy on port 'level'.
module decimator #(
    parameter int DataLengthBits   = 8,
    parameter int DecimationFactor = 4,
    parameter int PhaseOffset      = 0,
    parameter int Depth            = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          sync,
    input  logic [DataLengthBits-1:0]     in,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [DataLengthBits-1:0]     out,
    output logic                          out_valid,
    input  logic                          out_ready
`ifdef DECIMATOR_LEVEL_EN
    ,
    output logic [$clog2(Depth+1)-1:0]    level
`endif
);

    localparam int PW = (DecimationFactor > 1) ? $clog2(DecimationFactor) : 1;
    localparam int AW = $clog2(Depth);
    localparam int CW = $clog2(Depth + 1);

    localparam logic [PW-1:0] KeepPhase = PW'(PhaseOffset);
    localparam logic [PW-1:0] LastPhase = PW'(DecimationFactor - 1);
    localparam logic [AW-1:0] LastAddr  = AW'(Depth - 1);
    localparam logic [CW-1:0] FullCount = CW'(Depth);

    initial begin
        if (DecimationFactor < 1)
            $error("decimator: DecimationFactor must be >= 1");
        if (PhaseOffset < 0 || PhaseOffset >= DecimationFactor)
            $error("decimator: PhaseOffset must be in 0..DecimationFactor-1");
        if (Depth < 2)
            $error("decimator: Depth must be >= 2");
    end

    logic [PW-1:0]             phase;
    logic [PW-1:0]             phase_eval;
    logic [PW-1:0]             phase_next;
    logic [DataLengthBits-1:0] mem [Depth];
    logic [AW-1:0]             rd_ptr;
    logic [AW-1:0]             wr_ptr;
    logic [AW-1:0]             rd_next;
    logic [AW-1:0]             wr_next;
    logic [CW-1:0]             count;
    logic [DataLengthBits-1:0] head;
    logic                      keep;
    logic                      accept;
    logic                      push;
    logic                      pop;

    assign out_valid = (count != '0);
    assign out       = head;

`ifdef DECIMATOR_LEVEL_EN
    assign level = count;
`endif

    // sync redirects the sample of this very cycle to phase 0 before the keep decision
    always_comb begin
        phase_eval = sync ? '0 : phase;
        keep       = (phase_eval == KeepPhase);
        pop        = out_valid && out_ready;
        in_ready   = rst && (!keep || (count != FullCount) || pop);
        accept     = in_valid && in_ready;
        push       = accept && keep;
        phase_next = phase_eval;
        if (accept)
            phase_next = (phase_eval == LastPhase) ? '0 : phase_eval + PW'(1);
        rd_next = (rd_ptr == LastAddr) ? '0 : rd_ptr + AW'(1);
        wr_next = (wr_ptr == LastAddr) ? '0 : wr_ptr + AW'(1);
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= in;
    end

    // head is kept in its own register so out is glitch-free and clears on reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            head   <= '0;
        end else begin
            phase <= phase_next;
            if (push)
                wr_ptr <= wr_next;
            if (pop)
                rd_ptr <= rd_next;
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (pop && count > CW'(1))
                head <= mem[rd_next];
            else if (push && (count == '0 || (pop && count == CW'(1))))
                head <= in;
        end
    end

endmodule

// File: tb/tb_decimator.sv
// Directed bench for decimator: pass-through, backpressure, full push/pop, sync, async reset
// and a second instance with PhaseOffset=3.
module tb_decimator;

    logic       clk;
    logic       rst;
    logic       sync;
    logic [7:0] din;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] dout;
    logic       out_valid;
    logic       out_ready;

    logic       sync3;
    logic [7:0] din3;
    logic       in_valid3;
    logic       in_ready3;
    logic [7:0] dout3;
    logic       out_valid3;
    logic       out_ready3;

`ifdef DECIMATOR_LEVEL_EN
    logic [2:0] level;
    logic [2:0] level3;
`endif

    int checks = 0;
    int errors = 0;

    decimator #(.DataLengthBits(8), .DecimationFactor(4), .PhaseOffset(0), .Depth(4)) u_dut (
        .clk(clk), .rst(rst), .sync(sync), .in(din), .in_valid(in_valid), .in_ready(in_ready),
        .out(dout), .out_valid(out_valid), .out_ready(out_ready)
`ifdef DECIMATOR_LEVEL_EN
        , .level(level)
`endif
    );

    decimator #(.DataLengthBits(8), .DecimationFactor(4), .PhaseOffset(3), .Depth(4)) u_dut3 (
        .clk(clk), .rst(rst), .sync(sync3), .in(din3), .in_valid(in_valid3), .in_ready(in_ready3),
        .out(dout3), .out_valid(out_valid3), .out_ready(out_ready3)
`ifdef DECIMATOR_LEVEL_EN
        , .level(level3)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] sample, input logic valid,
                                 input logic ordy, input logic syn);
        din       = sample;
        in_valid  = valid;
        out_ready = ordy;
        sync      = syn;
        #2;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    initial begin
        rst        = 1'b0;
        sync       = 1'b0;
        din        = '0;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        sync3      = 1'b0;
        din3       = '0;
        in_valid3  = 1'b0;
        out_ready3 = 1'b0;

        #3;
        checkOutput("reset_in_ready", 32'(in_ready), 0);
        checkOutput("reset_out_valid", 32'(out_valid), 0);
        checkOutput("reset_out", 32'(dout), 0);
        @(negedge clk);
        rst = 1'b1;
        tick();
        applyStimulus(8'd0, 1'b0, 1'b1, 1'b0);
        checkOutput("post_reset_in_ready", 32'(in_ready), 1);

        // streaming: keep 0, 4, 8 one cycle after acceptance
        for (int i = 0; i <= 12; i++) begin
            applyStimulus(8'(i), (i < 12), 1'b1, 1'b0);
            if (i < 12)
                checkOutput("stream_in_ready", 32'(in_ready), 1);
            if (i >= 1 && ((i - 1) % 4) == 0) begin
                checkOutput("stream_out_valid", 32'(out_valid), 1);
                checkOutput("stream_out", 32'(dout), 32'(i - 1));
            end else begin
                checkOutput("stream_out_idle", 32'(out_valid), 0);
            end
            tick();
        end

        // backpressure fills the FIFO with 0, 4, 8, 12
        for (int v = 0; v < 16; v++) begin
            applyStimulus(8'(v), 1'b1, 1'b0, 1'b0);
            checkOutput("bp_in_ready", 32'(in_ready), 1);
            if (v > 0) begin
                checkOutput("bp_out_valid", 32'(out_valid), 1);
                checkOutput("bp_out_head", 32'(dout), 0);
            end
            tick();
        end
        applyStimulus(8'd16, 1'b1, 1'b0, 1'b0);
        checkOutput("full_in_ready", 32'(in_ready), 0);
`ifdef DECIMATOR_LEVEL_EN
        checkOutput("full_level", 32'(level), 4);
`endif
        tick();
        applyStimulus(8'd16, 1'b1, 1'b0, 1'b0);
        checkOutput("full_hold_in_ready", 32'(in_ready), 0);
        checkOutput("full_hold_out", 32'(dout), 0);
        tick();

        // full FIFO: pop and kept push together
        applyStimulus(8'd16, 1'b1, 1'b1, 1'b0);
        checkOutput("pushpop_in_ready", 32'(in_ready), 1);
        checkOutput("pushpop_out", 32'(dout), 0);
        tick();
        applyStimulus(8'd17, 1'b1, 1'b1, 1'b0);
        checkOutput("drain_out_4", 32'(dout), 4);
        checkOutput("drain_valid_4", 32'(out_valid), 1);
`ifdef DECIMATOR_LEVEL_EN
        checkOutput("pushpop_level", 32'(level), 4);
`endif
        tick();
        applyStimulus(8'd18, 1'b1, 1'b1, 1'b0);
        checkOutput("drain_out_8", 32'(dout), 8);
        tick();
        applyStimulus(8'd19, 1'b1, 1'b1, 1'b0);
        checkOutput("drain_out_12", 32'(dout), 12);
        tick();
        applyStimulus(8'd0, 1'b0, 1'b1, 1'b0);
        checkOutput("drain_out_16", 32'(dout), 16);
        checkOutput("drain_valid_16", 32'(out_valid), 1);
        tick();
        applyStimulus(8'd0, 1'b0, 1'b1, 1'b0);
        checkOutput("drain_empty", 32'(out_valid), 0);
        tick();

        // advance phase to 2, then sync together with sample 50
        applyStimulus(8'd30, 1'b1, 1'b1, 1'b0);
        tick();
        applyStimulus(8'd31, 1'b1, 1'b1, 1'b0);
        checkOutput("pre_sync_out", 32'(dout), 30);
        tick();
        applyStimulus(8'd50, 1'b1, 1'b1, 1'b1);
        checkOutput("sync_in_ready", 32'(in_ready), 1);
        checkOutput("sync_idle", 32'(out_valid), 0);
        tick();
        applyStimulus(8'd51, 1'b1, 1'b1, 1'b0);
        checkOutput("sync_kept_valid", 32'(out_valid), 1);
        checkOutput("sync_kept_out", 32'(dout), 50);
        tick();
        applyStimulus(8'd52, 1'b1, 1'b1, 1'b0);
        checkOutput("sync_discard_52", 32'(out_valid), 0);
        tick();
        applyStimulus(8'd53, 1'b1, 1'b1, 1'b0);
        checkOutput("sync_discard_53", 32'(out_valid), 0);
        tick();
        applyStimulus(8'd0, 1'b0, 1'b1, 1'b0);
        checkOutput("sync_discard_51", 32'(out_valid), 0);
        tick();

        // buffer 60, 64, 68 then assert reset between edges
        for (int v = 60; v <= 68; v++) begin
            applyStimulus(8'(v), 1'b1, 1'b0, 1'b0);
            tick();
        end
        applyStimulus(8'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("prereset_out", 32'(dout), 60);
`ifdef DECIMATOR_LEVEL_EN
        checkOutput("prereset_level", 32'(level), 3);
`endif
        #1;
        rst = 1'b0;
        #1;
        checkOutput("async_reset_out_valid", 32'(out_valid), 0);
        checkOutput("async_reset_out", 32'(dout), 0);
        checkOutput("async_reset_in_ready", 32'(in_ready), 0);
`ifdef DECIMATOR_LEVEL_EN
        checkOutput("async_reset_level", 32'(level), 0);
`endif
        @(negedge clk);
        rst = 1'b1;
        tick();
        applyStimulus(8'd70, 1'b1, 1'b1, 1'b0);
        checkOutput("after_reset_in_ready", 32'(in_ready), 1);
        tick();
        applyStimulus(8'd0, 1'b0, 1'b1, 1'b0);
        checkOutput("after_reset_valid", 32'(out_valid), 1);
        checkOutput("after_reset_out", 32'(dout), 70);
        tick();

        // PhaseOffset=3 instance keeps 3 and 7
        out_ready3 = 1'b1;
        for (int i = 0; i <= 8; i++) begin
            din3      = 8'(i);
            in_valid3 = (i < 8);
            #2;
            if (i < 8)
                checkOutput("ph3_in_ready", 32'(in_ready3), 1);
            if (i == 4 || i == 8) begin
                checkOutput("ph3_out_valid", 32'(out_valid3), 1);
                checkOutput("ph3_out", 32'(dout3), 32'(i - 1));
            end else begin
                checkOutput("ph3_idle", 32'(out_valid3), 0);
            end
            tick();
        end
        in_valid3 = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
